// File: rtl/rv_mem_pkg.sv
// Shared MEM-stage definitions: RV32I load/store funct3 codes,
// FSM state encoding, load-type flags and small decode helpers.
package rv_mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RSP  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   typedef struct packed {
      logic lb;
      logic lbu;
      logic lh;
      logic lhu;
      logic lw;
   } ld_type_t;

   function automatic logic f3_legal(
      input logic       we,
      input logic [2:0] f3
   );
      logic ok;
      if (we) begin
         ok = (f3 == F3_SB) || (f3 == F3_SH) ||
              (f3 == F3_SW);
      end else begin
         ok = (f3 == F3_LB)  || (f3 == F3_LH)  ||
              (f3 == F3_LW)  || (f3 == F3_LBU) ||
              (f3 == F3_LHU);
      end
      return ok;
   endfunction

   function automatic ld_type_t ld_decode(
      input logic [2:0] f3
   );
      ld_type_t t;
      t = '0;
      case (f3)
         F3_LB:   t.lb  = 1'b1;
         F3_LBU:  t.lbu = 1'b1;
         F3_LH:   t.lh  = 1'b1;
         F3_LHU:  t.lhu = 1'b1;
         F3_LW:   t.lw  = 1'b1;
         default: t = '0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/store_align.sv
// Store lane alignment: replicates rs2 across byte lanes, builds the
// byte-enable mask and flags misaligned half/word accesses.
// Ports: funct3_i, off_i, rs2_i -> be_o, wdata_o, misalign_o.
module store_align
   import rv_mem_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] rs2_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic        misalign_o
);

   logic is_b;
   logic is_h;
   logic is_w;

   // Size field is shared by loads and stores, so misalign
   // is valid for both directions.
   assign is_b = funct3_i[1:0] == F3_SB[1:0];
   assign is_h = funct3_i[1:0] == F3_SH[1:0];
   assign is_w = funct3_i[1:0] == F3_SW[1:0];

   always_comb begin
      be_o       = 4'b0000;
      wdata_o    = '0;
      misalign_o = 1'b0;
      unique case (1'b1)
         is_b: begin
            be_o    = 4'b0001 << off_i;
            wdata_o = {4{rs2_i[7:0]}};
         end
         is_h: begin
            be_o       = 4'b0011 << off_i;
            wdata_o    = {2{rs2_i[15:0]}};
            misalign_o = off_i[0];
         end
         is_w: begin
            be_o       = 4'b1111;
            wdata_o    = rs2_i;
            misalign_o = |off_i;
         end
         default: begin
            be_o = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access controller: one load/store per op,
// req/gnt/rvalid handshake, pipeline stall, timeout and load capture.
// Ports: req_* from EX/MEM; dmem_* to/from data memory; stall/fault
// to the pipeline; ld_* raw word, offset and type for load extraction.
module dmem_access_unit
   import rv_mem_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic              fault,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [31:0]       dmem_rdata,
   output logic              ld_valid,
   output logic [31:0]       ld_data,
   output logic [1:0]        ld_off,
   output logic              ld_lb,
   output logic              ld_lbu,
   output logic              ld_lh,
   output logic              ld_lhu,
   output logic              ld_lw
);

   state_e            state_q;
   state_e            state_d;
   logic [TO_W-1:0]   cnt_q;
   logic [TO_W-1:0]   cnt_d;
   logic              fault_q;
   logic              fault_d;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        off_q;
   logic [3:0]        be_q;
   logic [31:0]       wdata_q;
   logic [31:0]       ld_data_q;
   logic [1:0]        ld_off_q;
   ld_type_t          ld_type_q;

   logic              latch;
   logic              cap;
   logic              op_ok;
   logic              to_hit;
   logic [3:0]        sa_be;
   logic [31:0]       sa_wdata;
   logic              sa_mis;

   store_align u_align (
      .funct3_i   (req_funct3),
      .off_i      (req_addr[1:0]),
      .rs2_i      (req_wdata),
      .be_o       (sa_be),
      .wdata_o    (sa_wdata),
      .misalign_o (sa_mis)
   );

   assign op_ok  = f3_legal(req_we, req_funct3) && !sa_mis;
   // cnt_q counts cycles already spent in REQ/RSP, so this is
   // the last permitted cycle of the access.
   assign to_hit = cnt_q == TO_W'(TIMEOUT - 1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fault_d = fault_q;
      latch   = 1'b0;
      cap     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               latch = 1'b1;
               if (op_ok) begin
                  fault_d = 1'b0;
                  cnt_d   = '0;
                  state_d = S_REQ;
               end else begin
                  fault_d = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + TO_W'(1);
            if (dmem_gnt) begin
               state_d = we_q ? S_DONE : S_RSP;
            end else if (to_hit) begin
               fault_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_RSP: begin
            cnt_d = cnt_q + TO_W'(1);
            if (dmem_rvalid) begin
               cap     = 1'b1;
               state_d = S_DONE;
            end else if (to_hit) begin
               fault_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= '0;
         off_q   <= 2'b00;
         be_q    <= 4'b0000;
         wdata_q <= '0;
      end else if (latch) begin
         we_q    <= req_we;
         f3_q    <= req_funct3;
         addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
         off_q   <= req_addr[1:0];
         be_q    <= req_we ? sa_be : 4'b0000;
         wdata_q <= sa_wdata;
      end
   end

   // Load results persist across stores and faults until the
   // next load's data returns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_data_q <= '0;
         ld_off_q  <= 2'b00;
         ld_type_q <= '0;
      end else if (cap) begin
         ld_data_q <= dmem_rdata;
         ld_off_q  <= off_q;
         ld_type_q <= ld_decode(f3_q);
      end
   end

   // rst_n gates stall so a held req_valid cannot keep the
   // pipeline frozen while the unit is being reset.
   assign stall      = rst_n && req_valid &&
                       (state_q != S_DONE);
   assign dmem_req   = state_q == S_REQ;
   assign dmem_we    = dmem_req && we_q;
   assign dmem_addr  = dmem_req ? addr_q : '0;
   assign dmem_be    = dmem_req ? be_q : 4'b0000;
   assign dmem_wdata = dmem_req ? wdata_q : '0;

   assign fault    = (state_q == S_DONE) && fault_q;
   assign ld_valid = (state_q == S_DONE) && !fault_q &&
                     !we_q;
   assign ld_data  = ld_data_q;
   assign ld_off   = ld_off_q;
   assign ld_lb    = ld_type_q.lb;
   assign ld_lbu   = ld_type_q.lbu;
   assign ld_lh    = ld_type_q.lh;
   assign ld_lhu   = ld_type_q.lhu;
   assign ld_lw    = ld_type_q.lw;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: directed scenarios plus
// randomized loads/stores against a byte-level memory model.
module tb_dmem_access_unit;

   localparam int TIMEOUT = 255;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        fault;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic [1:0]  ld_off;
   logic        ld_lb;
   logic        ld_lbu;
   logic        ld_lh;
   logic        ld_lhu;
   logic        ld_lw;

   always #5 clk = ~clk;

   dmem_access_unit #(
      .ADDR_W  (32),
      .TIMEOUT (TIMEOUT),
      .TO_W    (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_we      (req_we),
      .req_funct3  (req_funct3),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .stall       (stall),
      .fault       (fault),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_be     (dmem_be),
      .dmem_wdata  (dmem_wdata),
      .dmem_gnt    (dmem_gnt),
      .dmem_rvalid (dmem_rvalid),
      .dmem_rdata  (dmem_rdata),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .ld_off      (ld_off),
      .ld_lb       (ld_lb),
      .ld_lbu      (ld_lbu),
      .ld_lh       (ld_lh),
      .ld_lhu      (ld_lhu),
      .ld_lw       (ld_lw)
   );

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } mreq_t;

   typedef struct packed {
      logic        is_fault;
      logic [31:0] data;
      logic [1:0]  off;
      logic [4:0]  flags;
   } res_t;

   mreq_t       mq[$];
   res_t        rq[$];
   logic [31:0] ref_mem [16];
   logic [31:0] dut_mem [16];
   int          gnt_delay = 0;
   int          rv_delay  = 1;
   int          checks    = 0;
   int          failures  = 0;
   int          ldv_cnt   = 0;
   logic [31:0] hold_data;
   logic [1:0]  hold_off;
   logic [4:0]  hold_flags;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp,
                  $time);
      end
   endtask

   // Memory responder: checks each presented request against
   // the head of the request queue, grants after gnt_delay
   // cycles, and returns read data rv_delay cycles later.
   int          req_seen = 0;
   int          pend     = 0;
   logic [31:0] paddr;
   mreq_t       hm;

   always @(negedge clk) begin
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = $urandom;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = dut_mem[paddr[5:2]];
         end
      end else if (!req_valid && $urandom_range(3) == 0) begin
         dmem_rvalid = 1'b1;
      end
      if (rst_n && dmem_req) begin
         if (mq.size() == 0) begin
            chk("req_unexpected", 64'(dmem_req), 64'(0));
         end else begin
            hm = mq[0];
            chk("req_we", 64'(dmem_we), 64'(hm.we));
            chk("req_addr", 64'(dmem_addr), 64'(hm.addr));
            chk("req_be", 64'(dmem_be), 64'(hm.be));
            if (hm.we)
               chk("req_wdata", 64'(dmem_wdata), 64'(hm.wdata));
            if (req_seen >= gnt_delay) begin
               dmem_gnt = 1'b1;
               void'(mq.pop_front());
               req_seen = 0;
               if (dmem_we) begin
                  for (int i = 0; i < 4; i++)
                     if (dmem_be[i])
                        dut_mem[dmem_addr[5:2]][8*i +: 8] =
                           dmem_wdata[8*i +: 8];
               end else if (rv_delay > 0) begin
                  pend  = rv_delay;
                  paddr = dmem_addr;
               end
            end else begin
               req_seen++;
            end
         end
      end else begin
         req_seen = 0;
         if ($urandom_range(3) == 0) dmem_gnt = 1'b1;
      end
   end

   // Result monitor: every ld_valid or fault pulse pops one
   // expected result; otherwise the load outputs must hold.
   res_t mr;

   always @(negedge clk) begin
      if (!rst_n) begin
         hold_data  = '0;
         hold_off   = '0;
         hold_flags = '0;
      end else begin
         if (fault) begin
            chk("fault_with_ldvalid", 64'(ld_valid), 64'(0));
            if (rq.size() == 0) begin
               chk("fault_unexpected", 64'(fault), 64'(0));
            end else begin
               mr = rq.pop_front();
               chk("fault_kind", 64'(fault), 64'(mr.is_fault));
            end
         end
         if (ld_valid) begin
            ldv_cnt++;
            if (rq.size() == 0) begin
               chk("ldv_unexpected", 64'(ld_valid), 64'(0));
            end else if (!fault) begin
               mr = rq.pop_front();
               chk("ld_kind", 64'(ld_valid), 64'(!mr.is_fault));
               chk("ld_data", 64'(ld_data), 64'(mr.data));
               chk("ld_off", 64'(ld_off), 64'(mr.off));
               chk("ld_flags",
                   64'({ld_lb, ld_lbu, ld_lh, ld_lhu, ld_lw}),
                   64'(mr.flags));
               hold_data  = mr.data;
               hold_off   = mr.off;
               hold_flags = mr.flags;
            end
         end else begin
            chk("ld_hold",
                {ld_data, 30'(0), ld_off},
                {hold_data, 30'(0), hold_off});
            chk("ld_hold_flags",
                64'({ld_lb, ld_lbu, ld_lh, ld_lhu, ld_lw}),
                64'(hold_flags));
         end
      end
   end

   // Issue one op, queue its expected request/result, and
   // measure how many cycles the pipeline is stalled.
   task automatic do_op(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr,
                        input logic [31:0] rs2,
                        input int gd, input int rd,
                        input string nm);
      int          nb;
      int          st;
      int          exp_st;
      bit          legal;
      logic [31:0] ba;
      mreq_t       m;
      res_t        r;
      nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      if (we) legal = f3 <= 3'd2;
      else    legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      m = '0;
      r = '0;
      @(posedge clk);
      #1;
      gnt_delay  = gd;
      rv_delay   = rd;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = rs2;
      if (!legal || (addr % nb) != 0) begin
         r.is_fault = 1'b1;
         rq.push_back(r);
         exp_st = 1;
      end else begin
         m.we   = we;
         m.addr = addr & 32'hFFFF_FFFC;
         for (int b = 0; b < nb; b++) begin
            if (we) m.be[addr[1:0] + b] = 1'b1;
            ba = addr + b;
            if (we) ref_mem[ba[5:2]][8*ba[1:0] +: 8] =
                       rs2[8*b +: 8];
         end
         for (int i = 0; i < 4; i++)
            m.wdata[8*i +: 8] = rs2[8*(i % nb) +: 8];
         mq.push_back(m);
         if (we) begin
            exp_st = 2 + gd;
         end else if (rd == 0) begin
            r.is_fault = 1'b1;
            rq.push_back(r);
            exp_st = 1 + TIMEOUT;
         end else begin
            r.data = ref_mem[addr[5:2]];
            r.off  = addr[1:0];
            case (f3)
               3'd0:    r.flags = 5'b10000;
               3'd4:    r.flags = 5'b01000;
               3'd1:    r.flags = 5'b00100;
               3'd5:    r.flags = 5'b00010;
               default: r.flags = 5'b00001;
            endcase
            rq.push_back(r);
            exp_st = 2 + gd + rd;
         end
      end
      st = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (!stall) break;
         st++;
      end
      chk({nm, "_stall"}, 64'(st), 64'(exp_st));
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom_range(1));
      req_funct3 = 3'($urandom_range(7));
      req_addr   = $urandom;
      req_wdata  = $urandom;
   endtask

   initial begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] ad;
      logic [31:0] v;
      int          base;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = '0;
      req_wdata  = '0;
      for (int i = 0; i < 16; i++) begin
         v          = $urandom;
         ref_mem[i] = v;
         dut_mem[i] = v;
      end
      ref_mem[0] = 32'hDEAD_BEEF;
      dut_mem[0] = 32'hDEAD_BEEF;

      repeat (2) @(negedge clk);
      chk("rst_stall", 64'(stall), 64'(0));
      chk("rst_fault", 64'(fault), 64'(0));
      chk("rst_dmem",
          64'({dmem_req, dmem_we, dmem_be}), 64'(0));
      chk("rst_dmem_addr", 64'(dmem_addr), 64'(0));
      chk("rst_dmem_wdata", 64'(dmem_wdata), 64'(0));
      chk("rst_ld",
          {ld_data, 25'(0), ld_valid, ld_off,
           ld_lb, ld_lbu, ld_lh, ld_lhu, ld_lw}, 64'(0));
      #2 rst_n = 1'b1;

      do_op(1'b0, 3'd2, 32'h100, 32'h0, 0, 1, "lw_100");
      do_op(1'b1, 3'd0, 32'h103, 32'hA5, 0, 1, "sb_103");
      do_op(1'b0, 3'd1, 32'h101, 32'h0, 0, 1, "lh_mis");
      do_op(1'b1, 3'd1, 32'h202, 32'h1234_5678, 5, 1, "sh_wait");
      do_op(1'b0, 3'd4, 32'h3, 32'h0, 0, 0, "lbu_to");
      do_op(1'b0, 3'd3, 32'h104, 32'h0, 0, 1, "ld_ill");
      do_op(1'b1, 3'd4, 32'h104, 32'h0, 0, 1, "st_ill");
      do_op(1'b1, 3'd2, 32'h106, 32'h0, 0, 1, "sw_mis");
      do_op(1'b0, 3'd4, 32'h103, 32'h0, 1, 2, "lbu_103");

      // Reset while the load waits in RSP; its late rvalid
      // must not produce a result.
      @(posedge clk);
      #1;
      gnt_delay  = 0;
      rv_delay   = 3;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'd2;
      req_addr   = 32'h104;
      mq.push_back('{1'b0, 32'h104, 4'b0000, 32'h0});
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_rsp_stall", 64'(stall), 64'(0));
      chk("rst_rsp_req", 64'(dmem_req), 64'(0));
      chk("rst_rsp_ldv", 64'(ld_valid), 64'(0));
      req_valid = 1'b0;
      mq.delete();
      rq.delete();
      base = ldv_cnt;
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("rst_late_rvalid", 64'(ldv_cnt - base), 64'(0));

      for (int n = 0; n < 150; n++) begin
         we = 1'($urandom_range(1));
         if ($urandom_range(3) != 0) begin
            if (we) f3 = 3'($urandom_range(2));
            else begin
               v  = $urandom_range(4);
               f3 = (v > 2) ? 3'(v + 1) : 3'(v);
            end
         end else begin
            f3 = 3'($urandom_range(7));
         end
         ad = 32'h100 + 32'($urandom_range(63));
         if ($urandom_range(1) == 1) begin
            if (f3[1:0] == 2'd1) ad[0] = 1'b0;
            if (f3[1:0] == 2'd2) ad[1:0] = 2'b00;
         end
         do_op(we, f3, ad, $urandom, $urandom_range(3),
               ($urandom_range(39) == 0) ? 0 :
               $urandom_range(3, 1), "rnd");
         repeat ($urandom_range(2)) @(posedge clk);
      end

      repeat (5) @(negedge clk);
      chk("end_rq_empty", 64'(rq.size()), 64'(0));
      chk("end_mq_empty", 64'(mq.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks,
               failures);
      $finish;
   end

endmodule
